// File: rtl/tt_um_top.sv
// Eight parallel microtiles; SEL picks which one is registered onto uo_out.
// Stateful tiles report their value from before the current edge's update.
module tt_um_top (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [2:0] {
    TILE_CNT  = 3'd0,
    TILE_ADD  = 3'd1,
    TILE_SHR  = 3'd2,
    TILE_ACC  = 3'd3,
    TILE_LFSR = 3'd4,
    TILE_POP  = 3'd5,
    TILE_INV  = 3'd6,
    TILE_ID   = 3'd7
  } tile_e;

  logic [7:0] r_cnt;
  logic [7:0] r_shr;
  logic [7:0] r_acc;
  logic [7:0] r_lfsr;
  logic [7:0] r_out;

  tile_e      w_sel;
  logic [4:0] w_d;
  logic [3:0] w_pop;
  logic [7:0] w_lfsr_next;
  logic [7:0] w_value;

  assign w_sel = tile_e'(ui_in[7:5]);
  assign w_d   = ui_in[4:0];

  // Galois right-shift LFSR with taps 0xB8; seeded non-zero so it never locks up
  assign w_lfsr_next = {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? 8'hB8 : 8'h00);

  always_comb begin
    w_pop = 4'd0;
    for (int i = 0; i < 8; i++) begin
      w_pop = w_pop + {3'b000, uio_in[i]};
    end
  end

  always_comb begin
    w_value = 8'h00;
    case (w_sel)
      TILE_CNT:  w_value = r_cnt;
      TILE_ADD:  w_value = {3'b000, w_d} + uio_in;
      TILE_SHR:  w_value = r_shr;
      TILE_ACC:  w_value = r_acc;
      TILE_LFSR: w_value = r_lfsr;
      TILE_POP:  w_value = {4'b0000, w_pop};
      TILE_INV:  w_value = ~uio_in;
      TILE_ID:   w_value = 8'hA5;
      default:   w_value = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= 8'h00;
      r_shr  <= 8'h00;
      r_acc  <= 8'h00;
      r_lfsr <= 8'h01;
      r_out  <= 8'h00;
    end else if (ena) begin
      r_cnt  <= r_cnt + 8'h01;
      r_shr  <= {r_shr[6:0], ui_in[0]};
      r_acc  <= r_acc + uio_in;
      r_lfsr <= w_lfsr_next;
      r_out  <= w_value;
    end
  end

  assign uo_out  = r_out;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_top.sv
// Self-checking bench for tt_um_top: constant vector tables, a reference model
// for long runs, and a scoreboard queue popped once per clock edge.
module tb_tt_um_top;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  always #5 clk = ~clk;

  tt_um_top dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  typedef struct {
    logic [2:0] sel;
    logic [4:0] d;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs[10];
  logic [7:0] lfsrSeq[6];
  logic [7:0] shrBits[5];
  logic [7:0] shrExp[5];
  logic [7:0] accExp[3];

  int nCompared   = 0;
  int nMismatched = 0;

  logic [7:0] expQ[$];
  logic [7:0] mCnt, mShr, mAcc, mLfsr, mOut;

  task automatic compare(input string name, input logic [7:0] act, input logic [7:0] req);
    nCompared++;
    if (act !== req) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%02h, required 0x%02h", name, act, req);
    end
  endtask

  // Reference behaviour of each tile, built from the tile descriptions
  function automatic logic [7:0] modelValue(input logic [2:0] sel, input logic [4:0] d,
                                            input logic [7:0] b);
    case (sel)
      3'd0:    return mCnt;
      3'd1:    return 8'({3'b000, d} + b);
      3'd2:    return mShr;
      3'd3:    return mAcc;
      3'd4:    return mLfsr;
      3'd5:    return 8'($countones(b));
      3'd6:    return ~b;
      default: return 8'hA5;
    endcase
  endfunction

  task automatic modelStep(input logic [4:0] d, input logic [7:0] b);
    mCnt  = mCnt + 8'h01;
    mShr  = {mShr[6:0], d[0]};
    mAcc  = mAcc + b;
    mLfsr = mLfsr[0] ? ({1'b0, mLfsr[7:1]} ^ 8'hB8) : {1'b0, mLfsr[7:1]};
  endtask

  task automatic modelReset();
    mCnt  = 8'h00;
    mShr  = 8'h00;
    mAcc  = 8'h00;
    mLfsr = 8'h01;
    mOut  = 8'h00;
    expQ.delete();
  endtask

  task automatic checkOutput(input string name);
    if (expQ.size() == 0) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%02h, required <empty scoreboard>", name, uo_out);
    end else begin
      compare(name, uo_out, expQ.pop_front());
    end
  endtask

  // Drives one cycle of inputs, queues the expected output, then checks after the edge
  task automatic applyStimulus(input logic [2:0] sel, input logic [4:0] d, input logic [7:0] b,
                               input logic en, input logic [7:0] exp, input bit useModel,
                               input string name);
    logic [7:0] want;
    ui_in  = {sel, d};
    uio_in = b;
    ena    = en;
    want   = useModel ? (en ? modelValue(sel, d, b) : mOut) : exp;
    expQ.push_back(want);
    if (en) begin
      mOut = modelValue(sel, d, b);
      modelStep(d, b);
    end
    @(posedge clk);
    #1;
    checkOutput(name);
  endtask

  task automatic resetDut();
    rst_n  = 1'b0;
    ena    = 1'($urandom);
    ui_in  = 8'($urandom);
    uio_in = 8'($urandom);
    repeat (2) @(posedge clk);
    #1;
    compare("reset uo_out", uo_out, 8'h00);
    compare("reset uio_out", uio_out, 8'h00);
    compare("reset uio_oe", uio_oe, 8'h00);
    #1;
    rst_n = 1'b1;
    modelReset();
  endtask

  initial begin
    vecs[0] = '{sel: 3'd1, d: 5'h1F, b: 8'hF0, exp: 8'h0F};
    vecs[1] = '{sel: 3'd5, d: 5'h00, b: 8'hB7, exp: 8'h06};
    vecs[2] = '{sel: 3'd6, d: 5'h00, b: 8'hB7, exp: 8'h48};
    vecs[3] = '{sel: 3'd7, d: 5'h0C, b: 8'h33, exp: 8'hA5};
    vecs[4] = '{sel: 3'd1, d: 5'h05, b: 8'h03, exp: 8'h08};
    vecs[5] = '{sel: 3'd1, d: 5'h1F, b: 8'hFF, exp: 8'h1E};
    vecs[6] = '{sel: 3'd5, d: 5'h00, b: 8'hFF, exp: 8'h08};
    vecs[7] = '{sel: 3'd5, d: 5'h00, b: 8'h00, exp: 8'h00};
    vecs[8] = '{sel: 3'd6, d: 5'h00, b: 8'h00, exp: 8'hFF};
    vecs[9] = '{sel: 3'd5, d: 5'h00, b: 8'h81, exp: 8'h02};
    lfsrSeq = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
    shrBits = '{8'h01, 8'h00, 8'h01, 8'h01, 8'h00};
    shrExp  = '{8'h00, 8'h01, 8'h02, 8'h05, 8'h0B};
    accExp  = '{8'h00, 8'h80, 8'h00};
    modelReset();

    resetDut();
    applyStimulus(3'd7, 5'h00, 8'h00, 1'b1, 8'hA5, 1'b0, "id after reset");

    resetDut();
    for (int i = 0; i < 4; i++)
      applyStimulus(3'd0, 5'h00, 8'h00, 1'b1, 8'(i), 1'b0, "cnt start");
    for (int i = 0; i < 3; i++)
      applyStimulus(3'd0, 5'($urandom), 8'($urandom), 1'b0, 8'h03, 1'b0, "cnt ena hold");
    applyStimulus(3'd0, 5'h00, 8'h00, 1'b1, 8'h04, 1'b0, "cnt resume");
    for (int i = 0; i < 256; i++)
      applyStimulus(3'd0, 5'h00, 8'h00, 1'b1, 8'(i + 5), 1'b0, "cnt wrap");

    for (int i = 0; i < 10; i++)
      applyStimulus(vecs[i].sel, vecs[i].d, vecs[i].b, 1'b1, vecs[i].exp, 1'b0, "comb table");

    resetDut();
    for (int i = 0; i < 6; i++)
      applyStimulus(3'd4, 5'h00, 8'h00, 1'b1, lfsrSeq[i], 1'b0, "lfsr start");
    for (int i = 0; i < 249; i++)
      applyStimulus(3'd4, 5'h00, 8'h00, 1'b1, 8'h00, 1'b1, "lfsr run");
    for (int i = 0; i < 6; i++)
      applyStimulus(3'd4, 5'h00, 8'h00, 1'b1, lfsrSeq[i], 1'b0, "lfsr period");

    resetDut();
    for (int i = 0; i < 5; i++)
      applyStimulus(3'd2, shrBits[i][4:0], 8'h00, 1'b1, shrExp[i], 1'b0, "shr feed");

    resetDut();
    for (int i = 0; i < 3; i++)
      applyStimulus(3'd3, 5'h00, 8'h80, 1'b1, accExp[i], 1'b0, "acc wrap");

    // Mixed tiles with random SEL and ena: every tile must keep running unseen
    for (int i = 0; i < 80; i++)
      applyStimulus(3'($urandom), 5'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0),
                    8'h00, 1'b1, "random mix");

    resetDut();
    for (int i = 0; i < 17; i++)
      applyStimulus(3'd0, 5'h00, 8'h00, 1'b1, 8'(i), 1'b0, "cnt to 0x10");
    #1;
    rst_n = 1'b0;
    #1;
    compare("async reset uo_out", uo_out, 8'h00);
    compare("async reset uio_oe", uio_oe, 8'h00);
    #1;
    rst_n = 1'b1;
    modelReset();
    for (int i = 0; i < 3; i++)
      applyStimulus(3'd0, 5'h00, 8'h00, 1'b1, 8'(i), 1'b0, "cnt after async reset");

    compare("final uio_out", uio_out, 8'h00);
    compare("final uio_oe", uio_oe, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
